// File: rtl/sa_pkg.sv
// ----------------------------------------------------------------------------
// sa_pkg
// Shared definitions for the systolic-array result path: lane geometry, the
// result writer state encoding and the lane-narrowing function.
//
// Build option:
//   RESULT_SAT_EN  defined   -> narrow_lane saturates to signed LANE_WIDTH
//                  undefined -> narrow_lane keeps acc[LANE_WIDTH-1:0] (wraps)
// ----------------------------------------------------------------------------
package sa_pkg;

    localparam int LANES         = 3;
    localparam int LANE_WIDTH    = 8;
    localparam int ACC_WIDTH     = 16;
    localparam int RW_ADDR_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

`ifdef RESULT_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] LANE_MAX =
        ACC_WIDTH'((1 << (LANE_WIDTH - 1)) - 1);
    // Two's complement: ~MAX is the most negative lane value.
    localparam logic signed [ACC_WIDTH-1:0] LANE_MIN = ~LANE_MAX;
`endif

    function automatic logic [LANE_WIDTH-1:0] narrow_lane(
        input logic signed [ACC_WIDTH-1:0] acc
    );
`ifdef RESULT_SAT_EN
        if (acc > LANE_MAX)
            return LANE_MAX[LANE_WIDTH-1:0];
        else if (acc < LANE_MIN)
            return LANE_MIN[LANE_WIDTH-1:0];
        else
            return acc[LANE_WIDTH-1:0];
`else
        return acc[LANE_WIDTH-1:0];
`endif
    endfunction

endpackage

// File: rtl/result_ram.sv
// ----------------------------------------------------------------------------
// result_ram
// Simple dual-port RAM holding packed result words. Contents are never
// cleared; only the registered read data resets.
//
// Ports:
//   clk    in   clock
//   rst    in   async active-high reset (read data register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data, one cycle after raddr;
//               a same-address write returns the old word
// ----------------------------------------------------------------------------
module result_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            r_mem[waddr] <= wdata;
    end

    // Non-blocking read of the array gives read-before-write on collisions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else
            rdata <= r_mem[raddr];
    end

endmodule

// File: rtl/result_writer.sv
// ----------------------------------------------------------------------------
// result_writer
// Write side of the systolic-array result memory. Each accepted row of LANES
// signed accumulators is narrowed per lane, packed (lane 0 in the MSBs) and
// written to consecutive RAM addresses starting at 0 for every frame.
//
// Build option: RESULT_SAT_EN selects saturating lane narrowing (see sa_pkg).
//
// Ports:
//   clk        in   clock
//   rst        in   async active-high reset
//   start      in   begin a frame (sampled in IDLE only)
//   frame_len  in   words in the frame, clamped to DEPTH
//   in_valid   in   in_data holds a row
//   in_ready   out  a row is accepted this cycle
//   in_data    in   LANES signed accumulators, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
//   busy       out  frame in progress
//   done       out  one-cycle pulse after the last word of a frame
//   overflow   out  last start requested more than DEPTH words
//   wr_count   out  words written in the current or last frame
//   rd_addr    in   read address
//   rd_data    out  registered read data
//
// state | meaning
// ------+---------------------------------------------------
// IDLE  | waiting for start; zero-length start pulses done
// FILL  | accepting rows, one RAM write per beat
// DONE  | single cycle after the last write, done asserted
// ----------------------------------------------------------------------------
module result_writer
    import sa_pkg::*;
#(
    parameter int ADDR_WIDTH = RW_ADDR_WIDTH,
    parameter int DATA_WIDTH = LANES * LANE_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_WIDTH:0]          frame_len,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*ACC_WIDTH-1:0]   in_data,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [ADDR_WIDTH:0]          wr_count,
    input  logic [ADDR_WIDTH-1:0]        rd_addr,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_fill;
    logic                    r_done;
    logic                    r_overflow;
    logic [ADDR_WIDTH:0]     r_len;
    logic [ADDR_WIDTH:0]     r_wr_count;
    logic [ADDR_WIDTH-1:0]   r_addr;

    logic                    w_fill_nxt;
    logic                    w_done_nxt;
    logic                    w_beat;
    logic                    w_last;
    logic                    w_start_zero;
    logic                    w_start_frame;
    logic [ADDR_WIDTH:0]     w_len_clamped;
    logic [DATA_WIDTH-1:0]   w_packed;

    assign w_start_zero  = (r_state == IDLE) && start && (frame_len == '0);
    assign w_start_frame = (r_state == IDLE) && start && (frame_len != '0);
    assign w_len_clamped = (frame_len > DEPTH_W) ? DEPTH_W : frame_len;

    // r_fill is only set while in FILL, so it doubles as the beat qualifier.
    assign w_beat = r_fill && in_valid;
    assign w_last = w_beat && (r_wr_count == (r_len - CNT_ONE));

    // State register; the output flags are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_fill  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_start_frame) w_state_nxt = FILL;
            FILL:    if (w_last)        w_state_nxt = DONE;
            DONE:                       w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_fill_nxt = (w_state_nxt == FILL);
        w_done_nxt = (w_state_nxt == DONE) || w_start_zero;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_overflow <= 1'b0;
            r_wr_count <= '0;
            r_addr     <= '0;
        end else if (w_start_frame) begin
            r_len      <= w_len_clamped;
            r_overflow <= (frame_len > DEPTH_W);
            r_wr_count <= '0;
            r_addr     <= '0;
        end else if (w_start_zero) begin
            r_overflow <= 1'b0;
            r_wr_count <= '0;
        end else if (w_beat) begin
            // A full-depth frame wraps r_addr to 0 only after its last write.
            r_addr     <= r_addr + ADDR_ONE;
            r_wr_count <= r_wr_count + CNT_ONE;
        end
    end

    always_comb begin
        w_packed = '0;
        for (int i = 0; i < LANES; i++) begin
            w_packed[DATA_WIDTH-1-i*LANE_WIDTH -: LANE_WIDTH] =
                narrow_lane(in_data[i*ACC_WIDTH +: ACC_WIDTH]);
        end
    end

    result_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_beat),
        .waddr (r_addr),
        .wdata (w_packed),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign in_ready = r_fill;
    assign busy     = r_fill;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign wr_count = r_wr_count;

endmodule
